// File: rtl/sobel_pkg.sv
// sobel_pkg: frame geometry and writer state encoding shared by the Sobel blocks.
package sobel_pkg;

  localparam int unsigned FRAME_W     = 800;
  localparam int unsigned FRAME_H     = 480;
  localparam int unsigned FRAME_WORDS = FRAME_W * FRAME_H;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    BURST     = 2'd2,
    DONE      = 2'd3
  } writer_state_e;

endpackage : sobel_pkg

// File: rtl/sobel_frame_writer.sv
// sobel_frame_writer: Avalon-MM burst write master that drains the Sobel result
// FIFO into one frame buffer at base_add and pulses endf after the last word.
// Optional build macro SOBEL_WRITER_STALL_CNT_EN adds the stall_cycles counter.
module sobel_frame_writer
  import sobel_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADD_WIDTH     = 32,
  parameter int unsigned BURST_WIDTH_W = 6,
  parameter int unsigned BURST_LEN     = 32,
  parameter int unsigned FRAME_WORDS   = sobel_pkg::FRAME_WORDS,
  parameter int unsigned USEDW_WIDTH   = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADD_WIDTH-1:0]       base_add,
  output logic                       endf,
  input  logic [DATA_WIDTH-1:0]      fifo_q,
  input  logic [USEDW_WIDTH-1:0]     fifo_usedw,
  output logic                       fifo_rdreq,
  output logic [ADD_WIDTH-1:0]       ram_w_address,
  output logic                       ram_w_write,
  output logic [DATA_WIDTH-1:0]      ram_w_writedata,
  output logic [DATA_WIDTH/8-1:0]    ram_w_byteenable,
  output logic [BURST_WIDTH_W-1:0]   ram_w_burstcount,
  input  logic                       ram_w_waitrequest
`ifdef SOBEL_WRITER_STALL_CNT_EN
  ,
  output logic [31:0]                stall_cycles
`endif
);

  localparam int unsigned WL_W = 19;
  localparam int unsigned BE_W = DATA_WIDTH / 8;

  writer_state_e            state_q;
  logic [WL_W-1:0]          words_left_q;
  logic [BURST_WIDTH_W-1:0] beats_q;
  logic [BURST_WIDTH_W-1:0] bcount_q;
  logic [ADD_WIDTH-1:0]     addr_q;
  logic                     write_q;
  logic                     endf_q;

  logic [BURST_WIDTH_W-1:0] blen_c;
  logic                     data_ready_c;
  logic                     beat_acc_c;
  logic [ADD_WIDTH-1:0]     addr_step_c;
  logic                     start_ok_c;

  // Burst length, FIFO readiness, beat acceptance and end-of-burst address step
  always_comb begin
    blen_c = BURST_WIDTH_W'(BURST_LEN);
    if (words_left_q < WL_W'(BURST_LEN)) begin
      blen_c = BURST_WIDTH_W'(words_left_q);
    end
    data_ready_c = 32'(fifo_usedw) >= 32'(blen_c);
    beat_acc_c   = write_q & ~ram_w_waitrequest;
    addr_step_c  = ADD_WIDTH'(bcount_q) * ADD_WIDTH'(BE_W);
    start_ok_c   = start & ((state_q == IDLE) | (state_q == DONE));
  end

  // Writer FSM with address, burst and frame word counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      words_left_q <= '0;
      beats_q      <= '0;
      bcount_q     <= '0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      endf_q       <= 1'b0;
    end else begin
      endf_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            addr_q       <= base_add;
            words_left_q <= WL_W'(FRAME_WORDS);
            state_q      <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (data_ready_c) begin
            bcount_q <= blen_c;
            beats_q  <= blen_c;
            write_q  <= 1'b1;
            state_q  <= BURST;
          end
        end
        BURST: begin
          if (beat_acc_c) begin
            beats_q      <= beats_q - BURST_WIDTH_W'(1);
            words_left_q <= words_left_q - WL_W'(1);
            if (beats_q == BURST_WIDTH_W'(1)) begin
              write_q <= 1'b0;
              addr_q  <= addr_q + addr_step_c;
              if (words_left_q == WL_W'(1)) begin
                state_q <= DONE;
                endf_q  <= 1'b1;
              end else begin
                state_q <= WAIT_DATA;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SOBEL_WRITER_STALL_CNT_EN
  logic [31:0] stall_q;

  // Saturating count of cycles the slave stalls an active write
  always_ff @(posedge clk) begin
    if (rst || start_ok_c) begin
      stall_q <= '0;
    end else if (write_q && ram_w_waitrequest && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok_c;
`endif

  assign endf             = endf_q;
  assign ram_w_address    = addr_q;
  assign ram_w_write      = write_q;
  assign ram_w_burstcount = bcount_q;
  assign ram_w_byteenable = '1;
  assign ram_w_writedata  = fifo_q;
  assign fifo_rdreq       = beat_acc_c;

endmodule : sobel_frame_writer
